trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the RV32 core; owns the trap CSRs mstatus, mie, mip, mtvec, mepc, mcause and mtval.
Accepts synchronous exceptions, the three M-mode interrupt lines and mret, and arbitrates between them.
Quiesces the pipeline through a flush handshake, then updates the CSRs atomically and issues a single-cycle PC redirect.
Sits between decode/execute (requesters), the CSR access path and the fetch stage.

---
 rtl/trap_ctrl_pkg.sv | 52 +++++
 rtl/trap_irq_prio.sv | 28 ++
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// TRAP_CTRL_VECTORED_EN enables mtvec vectored mode (mode 01).
package trap_ctrl_pkg;

    typedef struct packed {
        logic [18:0] rsvd_hi;
        logic [1:0]  mpp;
        logic [2:0]  rsvd_mid;
        logic        mpie;
        logic [2:0]  rsvd_lo;
        logic        mie;
        logic [2:0]  rsvd_wpri;
    } mstatus_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic        is_irq;
        logic [30:0] code;
    } mcause_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        COMMIT = 2'd2
    } trap_state_t;

    // Only direct (00) and, when supported, vectored (01) modes are stored.
    function automatic logic [1:0] legal_mode(input logic [1:0] mode);
`ifdef TRAP_CTRL_VECTORED_EN
        return (mode == 2'b01) ? 2'b01 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

endpackage

// File: rtl/trap_irq_prio.sv
// Interrupt eligibility masking and fixed-priority encode (MEI > MSI > MTI).
module trap_irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic       global_ie,
    input  logic [2:0] enable,
    input  logic [2:0] pending,
    output logic       irq_valid,
    output logic [4:0] irq_code
);

    // Both vectors are ordered {external, timer, software}.
    logic [2:0] masked;

    always_comb begin
        masked    = pending & enable & {3{global_ie}};
        irq_valid = |masked;
        irq_code  = 5'd0;
        if (masked[2]) begin
            irq_code = IRQ_MEI;
        end else if (masked[0]) begin
            irq_code = IRQ_MSI;
        end else if (masked[1]) begin
            irq_code = IRQ_MTI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrate, flush the pipeline, commit trap CSRs, redirect fetch.
// TRAP_CTRL_VECTORED_EN enables vectored interrupt targets (mtvec mode 01).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic        RESET_MIE   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [30:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        irq_msip,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    input  logic [31:0] irq_pc,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_busy
);

    trap_state_t state;
    logic        mstatus_mie, mstatus_mpie;
    logic [2:0]  mie_en;
    mtvec_t      mtvec;
    logic [31:0] mepc, mtval;
    mcause_t     mcause;

    logic        lat_mret;
    mcause_t     lat_cause;
    logic [31:0] lat_pc, lat_tval;

    logic        irq_valid;
    logic [4:0]  irq_code;

    trap_irq_prio u_prio (
        .global_ie (mstatus_mie),
        .enable    (mie_en),
        .pending   ({irq_meip, irq_mtip, irq_msip}),
        .irq_valid (irq_valid),
        .irq_code  (irq_code)
    );

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval;
    assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
    assign wr_mie     = csr_we && (csr_addr == CSR_MIE);
    assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
    assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
    assign wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);
    assign wr_mtval   = csr_we && (csr_addr == CSR_MTVAL);

    assign trap_busy = (state != IDLE);

    logic [31:0] trap_target;
    always_comb begin
        trap_target = {mtvec.base, 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
        if (mtvec.mode == 2'b01 && lat_cause.is_irq) begin
            trap_target = {mtvec.base, 2'b00} + {lat_cause.code[29:0], 2'b00};
        end
`endif
    end

    mstatus_t mstatus_rd;
    always_comb begin
        mstatus_rd      = '0;
        mstatus_rd.mpp  = 2'b11;
        mstatus_rd.mpie = mstatus_mpie;
        mstatus_rd.mie  = mstatus_mie;
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus_rd;
            CSR_MIE:     csr_rdata = {20'd0, mie_en[2], 3'd0, mie_en[1], 3'd0, mie_en[0], 3'd0};
            CSR_MTVEC:   csr_rdata = mtvec;
            CSR_MEPC:    csr_rdata = mepc;
            CSR_MCAUSE:  csr_rdata = mcause;
            CSR_MTVAL:   csr_rdata = mtval;
            CSR_MIP:     csr_rdata = {20'd0, irq_meip, 3'd0, irq_mtip, 3'd0, irq_msip, 3'd0};
            default:     csr_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_req      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            mstatus_mie    <= RESET_MIE;
            mstatus_mpie   <= 1'b0;
            mie_en         <= 3'd0;
            mtvec          <= {RESET_MTVEC[31:2], legal_mode(RESET_MTVEC[1:0])};
            mepc           <= 32'd0;
            mcause         <= '0;
            mtval          <= 32'd0;
            lat_mret       <= 1'b0;
            lat_cause      <= '0;
            lat_pc         <= 32'd0;
            lat_tval       <= 32'd0;
        end else begin
            redirect_valid <= 1'b0;

            // Software writes land first so the commit below overrides them.
            if (wr_mstatus) begin
                mstatus_mie  <= csr_wdata[3];
                mstatus_mpie <= csr_wdata[7];
            end
            if (wr_mie)    mie_en <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
            if (wr_mtvec)  mtvec  <= {csr_wdata[31:2], legal_mode(csr_wdata[1:0])};
            if (wr_mepc)   mepc   <= csr_wdata & ~32'd3;
            if (wr_mcause) mcause <= csr_wdata;
            if (wr_mtval)  mtval  <= csr_wdata;

            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        lat_mret  <= 1'b0;
                        lat_cause <= {1'b0, exc_cause};
                        lat_pc    <= exc_pc & ~32'd3;
                        lat_tval  <= exc_tval;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else if (irq_valid) begin
                        lat_mret  <= 1'b0;
                        lat_cause <= {1'b1, 26'd0, irq_code};
                        lat_pc    <= irq_pc & ~32'd3;
                        lat_tval  <= 32'd0;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else if (mret_valid) begin
                        lat_mret  <= 1'b1;
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        state     <= COMMIT;
                        flush_req <= 1'b0;
                    end
                end
                COMMIT: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b1;
                    if (lat_mret) begin
                        mstatus_mie  <= mstatus_mpie;
                        mstatus_mpie <= 1'b1;
                        redirect_pc  <= mepc;
                    end else begin
                        mepc         <= lat_pc;
                        mcause       <= lat_cause;
                        mtval        <= lat_tval;
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        redirect_pc  <= trap_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traps against a transaction-level model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

`ifdef TRAP_CTRL_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk, rst_n;
    logic        exc_valid;
    logic [30:0] exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret_valid;
    logic        irq_msip, irq_mtip, irq_meip;
    logic [31:0] irq_pc;
    logic        flush_req, flush_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata, csr_rdata;
    logic        trap_busy;

    trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip), .irq_pc(irq_pc),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .trap_busy(trap_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // reference model of architectural CSR state
    bit          m_ie, m_pie;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;

    function automatic logic [31:0] m_mstatus();
        return 32'h0000_1800 | (32'(m_pie) << 7) | (32'(m_ie) << 3);
    endfunction

    function automatic logic [31:0] legal_tvec(input logic [31:0] d);
        logic [31:0] r;
        r = d & ~32'd3;
        if (d[1:0] == 2'b01 && VEC) r = r | 32'd1;
        return r;
    endfunction

    task automatic model_reset();
        m_ie = 1'b0; m_pie = 1'b0;
        m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    // driver tasks
    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_addr = a; csr_wdata = d; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        case (a)
            CSR_MSTATUS: begin m_ie = d[3]; m_pie = d[7]; end
            CSR_MIE:     m_mie = d & 32'h0000_0888;
            CSR_MTVEC:   m_mtvec = legal_tvec(d);
            CSR_MEPC:    m_mepc = d & ~32'd3;
            CSR_MCAUSE:  m_mcause = d;
            CSR_MTVAL:   m_mtval = d;
            default: ;
        endcase
    endtask

    task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clk);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic check_csrs();
        csr_check("mstatus", CSR_MSTATUS, m_mstatus());
        csr_check("mie", CSR_MIE, m_mie);
        csr_check("mtvec", CSR_MTVEC, m_mtvec);
        csr_check("mepc", CSR_MEPC, m_mepc);
        csr_check("mcause", CSR_MCAUSE, m_mcause);
        csr_check("mtval", CSR_MTVAL, m_mtval);
        csr_check("mip", CSR_MIP, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One request cycle: model predicts the winner, bench runs the flush handshake.
    task automatic run_req(input bit exc, input logic [30:0] cause, input logic [31:0] pc,
                           input logic [31:0] tval, input bit mret, input logic [2:0] irqs,
                           input logic [31:0] ipc, input int ack_dly, input bit inject,
                           input bit commit_wr);
        int          kind;
        logic [4:0]  code;
        logic [2:0]  elig;
        logic [31:0] tgt;
        bit          got, extra;
        int          lat;

        elig = irqs & {m_mie[11], m_mie[7], m_mie[3]} & {3{m_ie}};
        kind = 0; code = 5'd0; tgt = 32'd0;
        if (exc) kind = 1;
        else if (elig != 3'd0) begin
            kind = 2;
            code = elig[2] ? 5'd11 : (elig[0] ? 5'd3 : 5'd7);
        end else if (mret) kind = 3;

        @(negedge clk);
        exc_valid = exc; exc_cause = cause; exc_pc = pc; exc_tval = tval;
        mret_valid = mret; {irq_meip, irq_mtip, irq_msip} = irqs; irq_pc = ipc;

        if (kind == 0) begin
            extra = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                exc_valid = 1'b0; mret_valid = 1'b0;
                if (flush_req || redirect_valid) extra = 1'b1;
            end
            check("no_accept", 32'(extra), 32'd0);
            {irq_meip, irq_mtip, irq_msip} = 3'd0;
            return;
        end

        case (kind)
            1: begin
                tgt = m_mtvec & ~32'd3;
                m_mepc = pc & ~32'd3; m_mcause = {1'b0, cause}; m_mtval = tval;
                m_pie = m_ie; m_ie = 1'b0;
            end
            2: begin
                tgt = m_mtvec & ~32'd3;
                if (m_mtvec[1:0] == 2'b01) tgt = tgt + 32'(code) * 32'd4;
                m_mepc = ipc & ~32'd3; m_mcause = 32'h8000_0000 | 32'(code); m_mtval = 32'd0;
                m_pie = m_ie; m_ie = 1'b0;
            end
            default: begin
                tgt = m_mepc;
                m_ie = m_pie; m_pie = 1'b1;
                if (commit_wr) m_mcause = 32'hFFFF_FFFF;
            end
        endcase
        exp_q.push_back(tgt);

        got = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("flush_req", 32'(flush_req), 32'd1);
                check("trap_busy", 32'(trap_busy), 32'd1);
                {irq_meip, irq_mtip, irq_msip} = 3'd0;
            end
            if (redirect_valid) begin
                got = 1'b1; lat = c;
                check("redirect_pc", redirect_pc, exp_q.pop_front());
                check("latency", 32'(lat), 32'(3 + ack_dly));
            end
            exc_valid  = inject && (c == 1);
            exc_cause  = 31'd5;
            mret_valid = 1'b0;
            flush_ack  = (c == 1 + ack_dly);
            csr_we     = commit_wr && (c == 2 + ack_dly);
            csr_addr   = CSR_MCAUSE;
            csr_wdata  = 32'hFFFF_FFFF;
        end
        flush_ack = 1'b0; csr_we = 1'b0; exc_valid = 1'b0;
        check("redirect_seen", 32'(got), 32'd1);
        if (!got) exp_q.delete();

        extra = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (flush_req || redirect_valid) extra = 1'b1;
        end
        check("single_redirect", 32'(extra), 32'd0);
        check_csrs();
    endtask

    initial begin
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; mret_valid = 0;
        irq_msip = 0; irq_mtip = 0; irq_meip = 0; irq_pc = 0; flush_ack = 0;
        csr_addr = 0; csr_we = 0; csr_wdata = 0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_flush_req", 32'(flush_req), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_trap_busy", 32'(trap_busy), 32'd0);
        check_csrs();

        // illegal instruction, ack on the second FLUSH cycle
        csr_write(CSR_MSTATUS, 32'h8);
        csr_write(CSR_MTVEC, 32'h100);
        run_req(1, 31'd2, 32'h104, 32'hDEAD, 0, 3'b000, 0, 1, 0, 0);
        csr_check("t1_mepc", CSR_MEPC, 32'h104);
        csr_check("t1_mcause", CSR_MCAUSE, 32'h2);
        csr_check("t1_mtval", CSR_MTVAL, 32'hDEAD);
        csr_check("t1_mstatus", CSR_MSTATUS, 32'h1880);

        // mret back to the faulting pc
        run_req(0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        csr_check("t4_mstatus", CSR_MSTATUS, 32'h1888);

        // timer interrupt, vectored when supported
        csr_write(CSR_MTVEC, 32'h201);
        csr_write(CSR_MIE, 32'h80);
        run_req(0, 0, 0, 0, 0, 3'b010, 32'h300, 0, 0, 0);
        csr_check("t2_mcause", CSR_MCAUSE, 32'h8000_0007);
        run_req(0, 0, 0, 0, 1, 3'b000, 0, 2, 0, 0);

        // priority: MEI beats MSI/MTI; exception beats all
        csr_write(CSR_MIE, 32'hFFFF_FFFF);
        run_req(0, 0, 0, 0, 0, 3'b111, 32'h404, 0, 0, 0);
        csr_check("t3_irq_mcause", CSR_MCAUSE, 32'h8000_000B);
        run_req(0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        run_req(1, 31'd11, 32'h508, 32'h77, 1, 3'b111, 32'h600, 0, 0, 0);
        csr_check("t3_exc_mcause", CSR_MCAUSE, 32'h0000_000B);

        // masking and drop while busy
        csr_write(CSR_MSTATUS, 32'h0);
        run_req(0, 0, 0, 0, 0, 3'b100, 32'h700, 0, 0, 0);
        run_req(1, 31'd4, 32'h808, 32'h1, 0, 3'b000, 0, 2, 1, 0);

        // reset mid-sequence
        csr_write(CSR_MTVEC, 32'h100);
        @(negedge clk);
        exc_valid = 1; exc_cause = 31'd6; exc_pc = 32'h900; exc_tval = 32'h9;
        @(negedge clk);
        exc_valid = 0;
        check("t6_flush_before_rst", 32'(flush_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_flush_async", 32'(flush_req), 32'd0);
        check("t6_busy_async", 32'(trap_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_csrs();
        csr_write(CSR_MTVEC, 32'h3);
        csr_check("t6_mtvec_illegal", CSR_MTVEC, 32'h0);

        // randomized traps, CSR traffic and commit-cycle writes
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) csr_write(CSR_MSTATUS, $urandom);
            if ($urandom_range(0, 2) == 0) csr_write(CSR_MIE, $urandom);
            if ($urandom_range(0, 3) == 0) csr_write(CSR_MTVEC, $urandom);
            if ($urandom_range(0, 3) == 0) csr_write(CSR_MEPC, $urandom);
            run_req($urandom_range(0, 2) == 0, 31'($urandom_range(0, 15)), $urandom, $urandom,
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
